// File: rtl/sound_frame_seq_if.sv
// Control inputs and tick/step outputs of the APU frame sequencer.
// master drives the enables and consumes the ticks; slave is the sequencer.
interface sound_frame_seq_if;
   logic       apu_on;
   logic       div_reset;
   logic       tick_length;
   logic       tick_sweep;
   logic       tick_env;
   logic [2:0] step;

   modport master (
      output apu_on,
      output div_reset,
      input  tick_length,
      input  tick_sweep,
      input  tick_env,
      input  step
   );

   modport slave (
      input  apu_on,
      input  div_reset,
      output tick_length,
      output tick_sweep,
      output tick_env,
      output step
   );
endinterface

// File: rtl/sound_frame_seq.sv
// GameBoy APU frame sequencer.
// Divides clk down to the step rate and emits registered length/sweep/envelope pulses.
module sound_frame_seq #(
   parameter int unsigned CLK_DIV = 8192
) (
   input  logic              clk,
   input  logic              rst,
   sound_frame_seq_if.slave  sq
);

   localparam int unsigned CW   = $clog2(CLK_DIV);
   localparam int unsigned SW   = 3;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

   logic [CW-1:0] cnt;
   logic [SW-1:0] step_q;
   logic          len_q;
   logic          sweep_q;
   logic          env_q;
   logic          tick_c;

   // A DIV write in the upper half of the period mimics the DIV bit falling edge.
   always_comb begin
      tick_c = 1'b0;
      if (sq.div_reset) begin
         tick_c = (cnt >= HALF);
      end else begin
         tick_c = (cnt == LAST);
      end
   end

   // Prescaler, step counter and decoded pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         step_q  <= '0;
         len_q   <= 1'b0;
         sweep_q <= 1'b0;
         env_q   <= 1'b0;
      end else if (!sq.apu_on) begin
         cnt     <= '0;
         step_q  <= '0;
         len_q   <= 1'b0;
         sweep_q <= 1'b0;
         env_q   <= 1'b0;
      end else begin
         cnt     <= (sq.div_reset || (cnt == LAST)) ? '0 : cnt + CW'(1);
         len_q   <= tick_c && !step_q[0];
         sweep_q <= tick_c && (step_q[1:0] == 2'd2);
         env_q   <= tick_c && (step_q == 3'd7);
         if (tick_c) begin
            step_q <= step_q + SW'(1);
         end
      end
   end

   assign sq.tick_length = len_q;
   assign sq.tick_sweep  = sweep_q;
   assign sq.tick_env    = env_q;
   assign sq.step        = step_q;

endmodule

// File: tb/tb_sound_frame_seq.sv
// Randomized bench for sound_frame_seq against a cycle-level model of the sequencer rules.
module tb_sound_frame_seq;

   localparam int DIV = 16;
   localparam logic [7:0] LEN_MAP = 8'b0101_0101;
   localparam logic [7:0] SWP_MAP = 8'b0100_0100;
   localparam logic [7:0] ENV_MAP = 8'b1000_0000;

   logic clk = 1'b0;
   logic rst;

   sound_frame_seq_if sq ();

   sound_frame_seq #(.CLK_DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .sq  (sq)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   int   m_phase = 0;
   int   m_step  = 0;
   logic e_len   = 1'b0;
   logic e_sw    = 1'b0;
   logic e_env   = 1'b0;

   logic [5:0] obs;
   assign obs = {sq.tick_length, sq.tick_sweep, sq.tick_env, sq.step};

   function automatic logic [5:0] exp_vec();
      return {e_len, e_sw, e_env, 3'(m_step)};
   endfunction

   task automatic model_clear();
      m_phase = 0;
      m_step  = 0;
      e_len   = 1'b0;
      e_sw    = 1'b0;
      e_env   = 1'b0;
   endtask

   // One clock: advance the model on the edge, return 1 time unit later.
   task automatic adv();
      bit fire;
      @(posedge clk);
      if (rst || !sq.apu_on) begin
         model_clear();
      end else begin
         fire    = sq.div_reset ? (m_phase >= DIV / 2) : (m_phase == DIV - 1);
         m_phase = sq.div_reset ? 0 : (m_phase + 1) % DIV;
         e_len   = fire && LEN_MAP[m_step];
         e_sw    = fire && SWP_MAP[m_step];
         e_env   = fire && ENV_MAP[m_step];
         if (fire) m_step = (m_step + 1) % 8;
      end
      #1;
   endtask

   // Cycles until the DUT step changes; -1 if it never does within the bound.
   task automatic wait_step_change(output int n);
      logic [2:0] s;
      s = sq.step;
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         adv();
         if (sq.step !== s) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sq.apu_on = 1'b0;
      sq.div_reset = 1'b0;
      #1;
      vecs++; if (obs !== 6'b0) begin errs++; $display("FAIL reset_async: got %b want %b", obs, 6'b0); end
      repeat (3) adv();
      vecs++; if (obs !== 6'b0) begin errs++; $display("FAIL reset_hold: got %b want %b", obs, 6'b0); end
      rst = 1'b0;
      adv();
      vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL reset_release: got %b want %b", obs, exp_vec()); end
   endtask

   task automatic test_full_sequence();
      int nl = 0, ns = 0, ne = 0, last = -1;
      bit prev = 1'b0;
      sq.apu_on = 1'b1;
      for (int i = 1; i <= 8 * DIV; i++) begin
         adv();
         vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL seq_cycle%0d: got %b want %b", i, obs, exp_vec()); end
         if (sq.tick_length === 1'b1) begin
            nl++;
            if (last >= 0) begin
               vecs++; if (i - last !== 2 * DIV) begin errs++; $display("FAIL seq_spacing: got %0d want %0d", i - last, 2 * DIV); end
            end
            vecs++; if (prev) begin errs++; $display("FAIL seq_width: got 2+ cycles want 1"); end
            last = i;
         end
         if (sq.tick_sweep === 1'b1) ns++;
         if (sq.tick_env === 1'b1) ne++;
         prev = sq.tick_length;
      end
      vecs++; if (nl !== 4) begin errs++; $display("FAIL seq_len_count: got %0d want 4", nl); end
      vecs++; if (ns !== 2) begin errs++; $display("FAIL seq_sweep_count: got %0d want 2", ns); end
      vecs++; if (ne !== 1) begin errs++; $display("FAIL seq_env_count: got %0d want 1", ne); end
      vecs++; if (sq.step !== 3'd0) begin errs++; $display("FAIL seq_step_wrap: got %0d want 0", sq.step); end
   endtask

   task automatic test_power_off();
      int n = -1;
      sq.apu_on = 1'b0;
      for (int i = 0; i < 100; i++) begin
         sq.div_reset = 1'($urandom_range(0, 1));
         adv();
         vecs++; if (obs !== 6'b0) begin errs++; $display("FAIL off_quiet: got %b want %b", obs, 6'b0); end
      end
      sq.div_reset = 1'b0;
      sq.apu_on = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         adv();
         if (sq.tick_length === 1'b1) begin
            n = i;
            break;
         end
      end
      vecs++; if (n !== DIV) begin errs++; $display("FAIL on_first_tick: got %0d want %0d", n, DIV); end
      vecs++; if (sq.step !== 3'd1) begin errs++; $display("FAIL on_first_step: got %0d want 1", sq.step); end
   endtask

   task automatic goto_phase(input int target);
      for (int g = 0; g < 40 && m_phase != target; g++) adv();
   endtask

   task automatic test_div_reset_high();
      int n, s0, tgt;
      for (int j = 0; j < 4; j++) begin
         tgt = (j == 0) ? 10 : int'($urandom_range(DIV / 2, DIV - 1));
         goto_phase(tgt);
         s0 = m_step;
         sq.div_reset = 1'b1;
         adv();
         sq.div_reset = 1'b0;
         vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL divhi_pulse cnt%0d: got %b want %b", tgt, obs, exp_vec()); end
         vecs++; if (sq.step !== 3'((s0 + 1) % 8)) begin errs++; $display("FAIL divhi_step cnt%0d: got %0d want %0d", tgt, sq.step, (s0 + 1) % 8); end
         wait_step_change(n);
         vecs++; if (n !== DIV) begin errs++; $display("FAIL divhi_next cnt%0d: got %0d want %0d", tgt, n, DIV); end
         vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL divhi_next_out: got %b want %b", obs, exp_vec()); end
      end
   endtask

   task automatic test_div_reset_low();
      int n, s0, tgt;
      for (int j = 0; j < 4; j++) begin
         tgt = (j == 0) ? 3 : int'($urandom_range(0, DIV / 2 - 1));
         goto_phase(tgt);
         s0 = m_step;
         sq.div_reset = 1'b1;
         adv();
         sq.div_reset = 1'b0;
         vecs++; if (obs !== {3'b000, 3'(s0)}) begin errs++; $display("FAIL divlo_none cnt%0d: got %b want %b", tgt, obs, {3'b000, 3'(s0)}); end
         wait_step_change(n);
         vecs++; if (n !== DIV) begin errs++; $display("FAIL divlo_next cnt%0d: got %0d want %0d", tgt, n, DIV); end
      end
   endtask

   task automatic test_apu_drop();
      for (int g = 0; g < 200 && !(m_step == 6 && m_phase == DIV - 1); g++) adv();
      vecs++; if (sq.step !== 3'd6) begin errs++; $display("FAIL drop_setup: got %0d want 6", sq.step); end
      sq.apu_on = 1'b0;
      adv();
      vecs++; if (obs !== 6'b0) begin errs++; $display("FAIL drop_quiet: got %b want %b", obs, 6'b0); end
      sq.apu_on = 1'b1;
   endtask

   task automatic test_rst_mid_pulse();
      int n;
      for (int g = 0; g < 200 && !e_len; g++) adv();
      vecs++; if (sq.tick_length !== 1'b1) begin errs++; $display("FAIL rst_setup: got %b want 1", sq.tick_length); end
      #2 rst = 1'b1;
      #1;
      vecs++; if (obs !== 6'b0) begin errs++; $display("FAIL rst_mid_clear: got %b want %b", obs, 6'b0); end
      model_clear();
      adv();
      rst = 1'b0;
      adv();
      vecs++; if (obs !== 6'b0) begin errs++; $display("FAIL rst_release: got %b want %b", obs, 6'b0); end
      wait_step_change(n);
      vecs++; if (n !== DIV - 1) begin errs++; $display("FAIL rst_first_tick: got %0d want %0d", n + 1, DIV); end
      vecs++; if (obs !== 6'b100_001) begin errs++; $display("FAIL rst_first_step0: got %b want %b", obs, 6'b100_001); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         sq.apu_on    = ($urandom_range(0, 99) < 97);
         sq.div_reset = ($urandom_range(0, 99) < 4);
         adv();
         vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL rand_cycle%0d: got %b want %b", i, obs, exp_vec()); end
      end
      sq.div_reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_sequence();
      test_power_off();
      test_div_reset_high();
      test_div_reset_low();
      test_apu_drop();
      test_rst_mid_pulse();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
